// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
// alu_sched : two-requester round-robin scheduler for one shared multi-cycle ALU
// Revision 1.0. Optional feature: define ALU_DIV0_TRAP_EN to reject div/mod by 0.
// ============================================================================
module alu_sched #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] result,
  output logic        zero,
  output logic        err,
  output logic [2:0]  alu_op,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_MUL_L = 4'(MUL_LAT);
  localparam logic [3:0] C_DIV_L = 4'(DIV_LAT);

  state_t      state_q, state_d;
  logic        rr_q, rr_d;          // 1: requester 1 wins the next tie
  logic        owner_q, owner_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] in1_q, in1_d;
  logic [15:0] in2_q, in2_d;
  logic [15:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;

  logic        pick1;
  logic [2:0]  sel_op;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic        bad_op;
  logic        div0;
  logic        gnt0_w, gnt1_w;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    gnt0_w   = 1'b0;
    gnt1_w   = 1'b0;

    pick1  = req1 && (!req0 || rr_q);
    sel_op = pick1 ? op1 : op0;
    sel_a  = pick1 ? a1  : a0;
    sel_b  = pick1 ? b1  : b0;
    bad_op = (sel_op == 3'd0) || (sel_op == 3'd7);
`ifdef ALU_DIV0_TRAP_EN
    div0   = ((sel_op == 3'd4) || (sel_op == 3'd5)) && (sel_b == 16'd0);
`else
    div0   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt0_w  = !pick1;
          gnt1_w  = pick1;
          owner_d = pick1;
          rr_d    = !pick1;
          op_d    = sel_op;
          if (bad_op || div0) begin
            // Rejected: never reaches the ALU, completes on the next cycle.
            state_d  = S_DONE;
            cnt_d    = 4'd0;
            result_d = div0 ? 16'hFFFF : 16'h0000;
            zero_d   = 1'b0;
            err_d    = 1'b1;
          end else begin
            state_d = S_EXEC;
            in1_d   = sel_a;
            in2_d   = sel_b;
            case (sel_op)
              3'd3:       cnt_d = C_MUL_L;
              3'd4, 3'd5: cnt_d = C_DIV_L;
              default:    cnt_d = 4'd1;
            endcase
          end
        end
      end
      S_EXEC: begin
        if (cnt_q <= 4'd1) begin
          state_d  = S_DONE;
          cnt_d    = 4'd0;
          result_d = alu_out;
          zero_d   = (alu_out == 16'd0);
          err_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      op_q     <= 3'd0;
      cnt_q    <= 4'd0;
      in1_q    <= 16'd0;
      in2_q    <= 16'd0;
      result_q <= 16'd0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  // Grants are combinational from IDLE; gate them so reset forces them low at once.
  assign gnt0    = gnt0_w && rst_n;
  assign gnt1    = gnt1_w && rst_n;
  assign done0   = (state_q == S_DONE) && !owner_q;
  assign done1   = (state_q == S_DONE) && owner_q;
  assign alu_op  = (state_q == S_EXEC) ? op_q : 3'd0;
  assign alu_in1 = in1_q;
  assign alu_in2 = in2_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ============================================================================
// tb_alu_sched : directed + randomized self-checking bench for alu_sched
// Revision 1.0
// ============================================================================
module tb_alu_sched;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] result;
  logic        zero, err;
  logic [2:0]  alu_op;
  logic [15:0] alu_in1, alu_in2, alu_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] last_in1, last_in2, last_res;
  logic        last_zero, last_err;

  always #5 clk = ~clk;

  alu_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .err(err),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out)
  );

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    case (op)
      3'd1: r = x + y;
      3'd2: r = x ^ y;
      3'd3: r = x * y;
      3'd4: r = (y == 16'd0) ? 16'hFFFF : x / y;
      3'd5: r = (y == 16'd0) ? x : x % y;
      3'd6: r = x << 1;
      default: r = 16'h0BAD;
    endcase
    return r;
  endfunction

  assign alu_out = alu_ref(alu_op, alu_in1, alu_in2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    checks++;
    assert (!(gnt0 && gnt1) && !(done0 && done1)) else begin
      errors++;
      $error("FAIL exclusive: gnt=%b%b done=%b%b expected one-hot or zero", gnt1, gnt0, done1, done0);
    end
  end

  task automatic drive(input int who, input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (who == 0) begin req0 = v; op0 = op; a0 = a; b0 = b; end
    else          begin req1 = v; op1 = op; a1 = a; b1 = b; end
  endtask

  task automatic wait_gnt(output int w);
    w = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (gnt0) begin w = 0; break; end
      if (gnt1) begin w = 1; break; end
    end
  endtask

  task automatic wait_done(output int w, output int c);
    w = -1; c = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done0 || done1) begin w = done1 ? 1 : 0; c = n; break; end
    end
  endtask

  // One full transaction for requester 'who'; optionally raises the other
  // requester during execution to show it is ignored until IDLE.
  task automatic run_op(input int who, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input bit intrude);
    bit rej, got;
    int lat, n, ex, bad, early;
    logic [15:0] er;
    rej = (op == 3'd0) || (op == 3'd7);
`ifdef ALU_DIV0_TRAP_EN
    if ((op == 3'd4 || op == 3'd5) && b == 16'd0) rej = 1'b1;
`endif
    lat = rej ? 0 : (op == 3'd3) ? MUL_LAT : (op == 3'd4 || op == 3'd5) ? DIV_LAT : 1;
    er  = rej ? ((op == 3'd0 || op == 3'd7) ? 16'h0000 : 16'hFFFF) : alu_ref(op, a, b);

    @(posedge clk); #1;
    drive(who, 1'b1, op, a, b);
    got = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (who == 0 ? gnt0 : gnt1) begin got = 1; break; end
    end
    chk("gnt_seen", 32'(got), 32'd1);
    chk("hold_result", {15'd0, err, zero, result}, {15'd0, last_err, last_zero, last_res});
    @(posedge clk); #1;
    drive(who, 1'b0, op, a, b);
    if (!got) return;
    if (intrude) drive(1 - who, 1'b1, 3'd1, 16'h0011, 16'h0022);

    got = 0; ex = 0; bad = 0; early = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (gnt0 || gnt1) early++;
      if (who == 0 ? done0 : done1) begin got = 1; break; end
      if (done0 || done1) early++;
      if (alu_op != 3'd0) begin
        ex++;
        if (alu_op !== op || alu_in1 !== a || alu_in2 !== b) bad++;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(n), 32'(lat + 1));
    chk("exec_cycles", 32'(ex), 32'(lat));
    chk("exec_stable", 32'(bad), 32'd0);
    chk("no_early", 32'(early), 32'd0);
    chk("result", {16'd0, result}, {16'd0, er});
    chk("zero", {31'd0, zero}, {31'd0, (!rej && er == 16'd0)});
    chk("err", {31'd0, err}, {31'd0, rej});
    if (rej) chk("alu_in_retain", {alu_in1, alu_in2}, {last_in1, last_in2});
    else begin last_in1 = a; last_in2 = b; end
    last_res = er; last_zero = !rej && er == 16'd0; last_err = rej;
  endtask

  initial begin
    int w, c;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    last_in1 = 0; last_in2 = 0; last_res = 0; last_zero = 0; last_err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {gnt0, gnt1, done0, done1, zero, err, alu_op, result, 11'd0},
                      32'd0);
    chk("reset_alu_in", {alu_in1, alu_in2}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Round-robin with both requests held
    @(posedge clk); #1;
    drive(0, 1'b1, 3'd2, 16'h1234, 16'h1234);
    drive(1, 1'b1, 3'd2, 16'h00F0, 16'h00F0);
    wait_gnt(w); chk("rr_first", 32'(w), 32'd0);
    @(posedge clk); #1 req0 = 0;
    wait_done(w, c); chk("rr_done0", 32'(w), 32'd0); chk("rr_lat0", 32'(c), 32'd2);
    chk("rr_zero0", {31'd0, zero}, 32'd1);
    wait_gnt(w); chk("rr_second", 32'(w), 32'd1);
    @(posedge clk); #1 req1 = 0;
    wait_done(w, c); chk("rr_done1", 32'(w), 32'd1); chk("rr_zero1", {31'd0, zero}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b1, 3'd1, 16'd1, 16'd2);
    drive(1, 1'b1, 3'd1, 16'd1, 16'd2);
    wait_gnt(w); chk("rr_third", 32'(w), 32'd0);
    @(posedge clk); #1 req0 = 0;
    wait_done(w, c);
    wait_gnt(w); chk("rr_fourth", 32'(w), 32'd1);
    @(posedge clk); #1 req1 = 0;
    wait_done(w, c); chk("rr_sum", {16'd0, result}, 32'd3);
    last_in1 = 16'd1; last_in2 = 16'd2; last_res = 16'd3; last_zero = 0; last_err = 0;

    run_op(0, 3'd1, 16'd5, 16'd7, 1'b0);
    chk("t1_result", {16'd0, result}, 32'd12);
    run_op(1, 3'd4, 16'd100, 16'd7, 1'b1);
    chk("t3_result", {16'd0, result}, 32'd14);
    run_op(0, 3'd1, 16'h0011, 16'h0022, 1'b0);
    run_op(0, 3'd7, 16'd9, 16'd9, 1'b0);
    run_op(0, 3'd5, 16'd9, 16'd0, 1'b0);
    run_op(1, 3'd3, 16'd300, 16'd500, 1'b0);
    run_op(0, 3'd6, 16'h8001, 16'd0, 1'b0);

    // Reset in the second EXEC cycle of a multiply
    @(posedge clk); #1 drive(0, 1'b1, 3'd3, 16'd3, 16'd4);
    wait_gnt(w); chk("t6_gnt", 32'(w), 32'd0);
    @(posedge clk); #1 req0 = 0;
    @(negedge clk); @(negedge clk);
    chk("t6_exec", {29'd0, alu_op}, 32'd3);
    #2 rst_n = 1'b0; req1 = 1'b1;
    #1;
    chk("t6_outs", {gnt0, gnt1, done0, done1, zero, err, alu_op, result, 11'd0}, 32'd0);
    chk("t6_alu_in", {alu_in1, alu_in2}, 32'd0);
    c = 0;
    repeat (3) begin @(negedge clk); if (done0 || done1 || gnt0 || gnt1) c++; end
    chk("t6_quiet", 32'(c), 32'd0);
    req1 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    c = 0;
    repeat (3) begin @(negedge clk); if (done0 || done1 || gnt0 || gnt1) c++; end
    chk("t6_no_pending", 32'(c), 32'd0);
    last_in1 = 0; last_in2 = 0; last_res = 0; last_zero = 0; last_err = 0;
    run_op(1, 3'd2, 16'hA5A5, 16'h0FF0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int who;
      logic [2:0] op;
      logic [15:0] a, b;
      bit intr;
      who  = int'($urandom_range(0, 1));
      op   = 3'($urandom_range(0, 7));
      a    = 16'($urandom);
      b    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      intr = ($urandom_range(0, 3) == 0);
      run_op(who, op, a, b, intr);
      if (intr) run_op(1 - who, 3'd1, 16'h0011, 16'h0022, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter MUL_LAT, default 3, meaning EXEC cycles for op 3 (multiply), legal range 1-15.
REQ-002 Parameter DIV_LAT, default 8, meaning EXEC cycles for ops 4 and 5 (divide, modulo), legal range 1-15.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active low.
REQ-005 reqN (N=0,1)  input  1  requester N wants an operation; held high until gntN.
REQ-006 opN (N=0,1)  input  3  requested ALU opcode: 1 add, 2 xor, 3 mul, 4 div, 5 mod, 6 shift-left-by-1.
REQ-007 aN, bN (N=0,1)  input  16  operand 1 (AC) and operand 2 (register).
REQ-008 gntN (N=0,1)  output  1  one-cycle pulse; request and operands accepted this cycle.
REQ-009 doneN (N=0,1)  output  1  one-cycle pulse; result, zero and err valid for requester N.
REQ-010 result  output  16  captured ALU result.
REQ-011 zero  output  1  high when result equals 0.
REQ-012 err  output  1  high when the completed operation was rejected.
REQ-013 alu_op  output  3  opcode driven to the shared ALU; 0 (hold) when not executing.
REQ-014 alu_in1, alu_in2  output  16  operands driven to the ALU.
REQ-015 alu_out  input  16  ALU result.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-017 IDLE: if any reqN is high, grant one; if both are high, grant the requester not granted last (round-robin; requester 0 wins the first tie after reset).
REQ-018 The grant cycle SHALL pulse gntN and latch opN, aN, bN and the owner ID.
REQ-019 On a legal opcode, the FSM SHALL go to EXEC with a latency counter loaded: ops 1, 2, 6 = 1; op 3 = MUL_LAT; ops 4, 5 = DIV_LAT.
REQ-020 On opcode 0 or 7, the FSM SHALL go directly to DONE with err=1, result=0, zero=0, and no cycle with alu_op nonzero.
REQ-021 EXEC: alu_op, alu_in1 and alu_in2 SHALL be held stable for exactly L cycles; alu_out SHALL be captured into result at the clock edge ending the L-th cycle; then go to DONE.
REQ-022 Latency: grant in cycle T -> doneN in cycle T+L+1 for legal ops, and T+1 for rejected ops.
REQ-023 zero SHALL be derived from the newly captured result, never from the previous value.
REQ-024 DONE: doneN of the owner SHALL be high for one cycle, then the FSM returns to IDLE; no grant is issued in DONE.
REQ-025 result, zero and err SHALL hold their values until the next DONE.
REQ-026 A req raised or dropped while the FSM is not in IDLE SHALL have no effect.
REQ-027 alu_op SHALL be 0 in IDLE and DONE; alu_in1 and alu_in2 SHALL retain their last values.
REQ-028 gnt0/gnt1 SHALL never be high together, and done0/done1 SHALL never be high together.

Reset
REQ-029 When rst_n is low, the block SHALL immediately force state IDLE, all outputs to 0, the round-robin pointer to "requester 0 next", and the latency counter to 0.
REQ-030 Reset during EXEC or DONE SHALL abort the operation with no doneN pulse, and no pending request SHALL be remembered.

Configuration
REQ-031 With macro ALU_DIV0_TRAP_EN defined, op 4 or 5 with bN==0 SHALL be rejected like an illegal opcode (DONE at T+1, err=1, result=16'hFFFF, zero=0, never issued to the ALU).
REQ-032 With ALU_DIV0_TRAP_EN undefined, a divide or modulo by zero SHALL be issued normally with err=0, and result SHALL be whatever alu_out returns.

Verification
REQ-033 Test 1: req0, op=1, a=5, b=7 -> gnt0 at T, alu_op=1 during T+1, done0 at T+2, result=12, zero=0, err=0.
REQ-034 Test 2: req0 and req1 held high together, both op=2 with equal operands -> gnt0, done0 (zero=1), then gnt1, done1; with both held again, the next grant goes to requester 0.
REQ-035 Test 3: req1, op=4, a=100, b=7, DIV_LAT=8 -> alu_op=4 for exactly 8 cycles, done1 at T+9, result=14.
REQ-036 Test 4: req0, op=7 -> done0 at T+1, err=1, result=0; alu_op stays 0 throughout.
REQ-037 Test 5: req0, op=5, b=0 -> with ALU_DIV0_TRAP_EN: done0 at T+1, err=1, result=16'hFFFF; without it: alu_op=5 for DIV_LAT cycles and err=0.
REQ-038 Test 6: rst_n pulsed low in the 2nd EXEC cycle of a multiply -> all outputs 0 immediately, no done pulse; a fresh req1 afterwards completes normally.
